// File: rtl/time_display_driver.sv
// time_display_driver
// Converts stopwatch minutes/seconds to BCD with a sequential double-dabble
// engine and scans them onto a 4-digit multiplexed 7-segment display as "mm:ss".
// The whole display blinks while the game is paused.
module time_display_driver #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] seconds,
   input  logic [4:0] minutes,
   input  logic       paused,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp,
   output logic       bcd_valid
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_LOAD  = 2'd2
   } conv_state_e;

   // Seconds beyond 59 are treated as 59 so the tens digit never exceeds 5.
   function automatic logic [5:0] clamp_sec(input logic [5:0] s);
      return (s > 6'd59) ? 6'd59 : s;
   endfunction

   // One double-dabble step on {tens, ones, bin}: adjust nibbles >= 5, then shift.
   function automatic logic [13:0] dabble_step(input logic [13:0] v);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = v[13:10];
      ones = v[9:6];
      if (tens >= 4'd5) tens = tens + 4'd3;
      if (ones >= 4'd5) ones = ones + 4'd3;
      return {tens, ones, v[5:0]} << 1;
   endfunction

   // Active-low {g,f,e,d,c,b,a} pattern for a decimal digit.
   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   conv_state_e     state_q,     state_d;
   logic [2:0]      step_q,      step_d;
   logic [13:0]     sec_sh_q,    sec_sh_d;
   logic [13:0]     min_sh_q,    min_sh_d;
   logic [10:0]     last_cap_q,  last_cap_d;
   logic [3:0][3:0] dig_q,       dig_d;
   logic [RW-1:0]   refresh_q,   refresh_d;
   logic [1:0]      idx_q,       idx_d;
   logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
   logic            blink_ph_q,  blink_ph_d;
   logic [3:0]      an_q,        an_d;
   logic [6:0]      seg_q,       seg_d;
   logic            dp_q,        dp_d;

   logic [5:0]  sec_clamped;
   logic [10:0] cap_val;

   assign sec_clamped = clamp_sec(seconds);
   assign cap_val     = {minutes, sec_clamped};

   // Converter FSM: capture a new value, run six dabble steps, load the digits.
   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      sec_sh_d   = sec_sh_q;
      min_sh_d   = min_sh_q;
      last_cap_d = last_cap_q;
      dig_d      = dig_q;
      case (state_q)
         S_IDLE: begin
            if (cap_val != last_cap_q) begin
               last_cap_d = cap_val;
               sec_sh_d   = {8'd0, sec_clamped};
               min_sh_d   = {8'd0, 1'b0, minutes};
               step_d     = 3'd0;
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sec_sh_d = dabble_step(sec_sh_q);
            min_sh_d = dabble_step(min_sh_q);
            step_d   = step_q + 3'd1;
            if (step_q == 3'd5) state_d = S_LOAD;
         end
         S_LOAD: begin
            dig_d   = {min_sh_q[13:10], min_sh_q[9:6], sec_sh_q[13:10], sec_sh_q[9:6]};
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Scan timing: each digit stays lit for REFRESH_DIV cycles.
   always_comb begin
      refresh_d = refresh_q + RW'(1);
      idx_d     = idx_q;
      if (refresh_q == REF_LAST) begin
         refresh_d = '0;
         idx_d     = idx_q + 2'd1;
      end
   end

   // Blink timing: runs only while paused, otherwise held cleared.
   always_comb begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      blink_ph_d  = blink_ph_q;
      if (!paused) begin
         blink_cnt_d = '0;
         blink_ph_d  = 1'b0;
      end else if (blink_cnt_q == BLK_LAST) begin
         blink_cnt_d = '0;
         blink_ph_d  = ~blink_ph_q;
      end
   end

   // Display outputs for the current scan slot; dp lights the colon on minutes ones.
   always_comb begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg_code(dig_q[idx_q]);
      dp_d  = (idx_q != 2'd2);
      if (blink_ph_q) begin
         an_d  = 4'b1111;
         seg_d = 7'h7F;
         dp_d  = 1'b1;
      end
   end

   // All state registers; reset also aborts any conversion in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         step_q      <= '0;
         sec_sh_q    <= '0;
         min_sh_q    <= '0;
         last_cap_q  <= '0;
         dig_q       <= '0;
         refresh_q   <= '0;
         idx_q       <= '0;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
         an_q        <= 4'b1110;
         seg_q       <= 7'b1000000;
         dp_q        <= 1'b1;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         sec_sh_q    <= sec_sh_d;
         min_sh_q    <= min_sh_d;
         last_cap_q  <= last_cap_d;
         dig_q       <= dig_d;
         refresh_q   <= refresh_d;
         idx_q       <= idx_d;
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
      end
   end

   assign an        = an_q;
   assign seg       = seg_q;
   assign dp        = dp_q;
   assign bcd_valid = (state_q == S_IDLE);

endmodule
